// File: rtl/pc_select_pkg.sv
// Shared fetch-side pipeline types: reset vector, pending redirect record and
// the fetch-stage PC bundle.
package pc_select_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

  typedef struct packed {
    logic        valid;
    logic        is_exc;
    logic [31:0] pc;
  } redirect_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        int_tag;
  } f_type_t;

endpackage

// File: rtl/pc_select_if.sv
// Signals between next-PC selection and its neighbours (fetch, decode, CP0).
interface pc_select_if;

  logic [31:0] pc_fetch;
  logic        pcf2;
  logic        stall_f;
  logic        br_valid;
  logic [31:0] br_target;
  logic        exc_valid;
  logic [31:0] exc_pc;
  logic        int_req;
  logic [31:0] f_pc;
  logic        f_int;
  logic        kill_d;
  logic        pend_valid;

  modport master (
    output pc_fetch, pcf2, stall_f, br_valid, br_target, exc_valid, exc_pc, int_req,
    input  f_pc, f_int, kill_d, pend_valid
  );

  modport slave (
    input  pc_fetch, pcf2, stall_f, br_valid, br_target, exc_valid, exc_pc, int_req,
    output f_pc, f_int, kill_d, pend_valid
  );

endinterface

// File: rtl/pc_select_redirect_hold.sv
// Holds a redirect that arrived while fetch could not advance; CP0 redirects
// outrank branches and a newer CP0 redirect replaces an older one.
module pc_select_redirect_hold
  import pc_select_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        advance_i,
  input  logic        exc_valid_i,
  input  logic [31:0] exc_pc_i,
  input  logic        br_valid_i,
  input  logic [31:0] br_target_i,
  output redirect_t   pend_o
);

  redirect_t pend_q, pend_d;

  always_comb begin
    pend_d = pend_q;
    if (advance_i) begin
      pend_d.valid  = 1'b0;
      pend_d.is_exc = 1'b0;
    end else if (exc_valid_i) begin
      pend_d.valid  = 1'b1;
      pend_d.is_exc = 1'b1;
      pend_d.pc     = exc_pc_i;
    end else if (br_valid_i && !pend_q.is_exc) begin
      // A branch behind a pending exception is wrong-path and is dropped.
      pend_d.valid = 1'b1;
      pend_d.pc    = br_target_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/pc_select.sv
// Next-PC selection and fetch PC register; redirects seen during a bus
// transaction are deferred so the PC only moves once fetch is free.
module pc_select
  import pc_select_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        resetn,
  pc_select_if.slave  bus
);

  redirect_t pend;
  f_type_t   f_q, f_d;
  logic      exc_any;
  logic      advance;

  always_comb begin
    exc_any = bus.exc_valid | pend.is_exc;
    // CP0 redirects override the hazard stall but never an in-flight bus access.
    advance = ~bus.pcf2 & (~bus.stall_f | exc_any);

    f_d.int_tag = bus.int_req & ~exc_any;
    if (bus.exc_valid) begin
      f_d.pc = bus.exc_pc;
    end else if (pend.is_exc) begin
      f_d.pc = pend.pc;
    end else if (bus.br_valid) begin
      f_d.pc = bus.br_target;
    end else if (pend.valid) begin
      f_d.pc = pend.pc;
    end else begin
      f_d.pc = bus.pc_fetch;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      f_q <= '{pc: RESET_PC, int_tag: 1'b0};
    end else if (advance) begin
      f_q <= f_d;
    end
  end

  pc_select_redirect_hold u_hold (
    .clk         (clk),
    .resetn      (resetn),
    .advance_i   (advance),
    .exc_valid_i (bus.exc_valid),
    .exc_pc_i    (bus.exc_pc),
    .br_valid_i  (bus.br_valid),
    .br_target_i (bus.br_target),
    .pend_o      (pend)
  );

  assign bus.f_pc       = f_q.pc;
  assign bus.f_int      = f_q.int_tag;
  assign bus.kill_d     = resetn & advance & exc_any;
  assign bus.pend_valid = pend.valid;

endmodule

// File: tb/tb_pc_select.sv
// Directed table of per-cycle inputs and hand-computed outputs for pc_select,
// followed by a short busy-bus exception sequence.
module tb_pc_select;

  logic clk = 1'b0;
  logic resetn;
  int   n_vec = 0;
  int   n_bad = 0;

  pc_select_if bus ();

  pc_select #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Fetch model: sequential successor of the current PC.
  assign bus.pc_fetch = bus.f_pc + 32'd4;

  typedef struct {
    logic        rstn;
    logic        pcf2;
    logic        stall;
    logic        br;
    logic [31:0] br_t;
    logic        exc;
    logic [31:0] exc_pc;
    logic        intr;
    logic [31:0] e_pc;
    logic        e_int;
    logic        e_kill;
    logic        e_pend;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rstn, logic pcf2, logic stall, logic br, logic [31:0] br_t,
                              logic exc, logic [31:0] exc_pc, logic intr, logic [31:0] e_pc,
                              logic e_int, logic e_kill, logic e_pend);
    vec_t v;
    v.rstn = rstn; v.pcf2 = pcf2; v.stall = stall; v.br = br; v.br_t = br_t;
    v.exc = exc; v.exc_pc = exc_pc; v.intr = intr;
    v.e_pc = e_pc; v.e_int = e_int; v.e_kill = e_kill; v.e_pend = e_pend;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic pcf2, input logic stall, input logic br,
                       input logic [31:0] br_t, input logic exc, input logic [31:0] exc_pc,
                       input logic intr);
    bus.pcf2 = pcf2; bus.stall_f = stall; bus.br_valid = br; bus.br_target = br_t;
    bus.exc_valid = exc; bus.exc_pc = exc_pc; bus.int_req = intr;
  endtask

  initial begin
    // Sequential fetch after reset
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'hBFC0_0000, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'hBFC0_0004, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'hBFC0_0008, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'hBFC0_000C, 0, 0, 0));
    // Branch during busy bus is held, applied when pcf2 drops
    tbl.push_back(mk(1, 1, 0, 1, 32'hBFC0_0100, 0, 0, 0, 32'hBFC0_0010, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 32'hBFC0_0010, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 32'hBFC0_0010, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'hBFC0_0010, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'hBFC0_0100, 0, 0, 0));
    // Direct branch, no pending state
    tbl.push_back(mk(1, 0, 0, 1, 32'h8000_0200, 0, 0, 0, 32'hBFC0_0104, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h8000_0200, 0, 0, 0));
    // Interrupt tag follows int_req on advance
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0204, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h8000_0208, 1, 0, 0));
    // Exception overrides stall, kills, clears f_int
    tbl.push_back(mk(1, 0, 1, 0, 0, 1, 32'hBFC0_0380, 1, 32'h8000_020C, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 32'hBFC0_0380, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'hBFC0_0380, 0, 0, 0));
    // Pending branch replaced by exception; later branch dropped
    tbl.push_back(mk(1, 1, 0, 1, 32'h0000_1000, 0, 0, 0, 32'hBFC0_0384, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 32'hBFC0_0380, 0, 32'hBFC0_0384, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 1, 32'h0000_2000, 0, 0, 0, 32'hBFC0_0384, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 32'hBFC0_0384, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'hBFC0_0380, 0, 0, 0));
    // Newest CP0 redirect wins; live exc_valid beats pending one
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 32'h8000_0180, 0, 32'hBFC0_0384, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 32'hBFC0_0200, 0, 32'hBFC0_0384, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 32'h8000_0000, 0, 32'hBFC0_0384, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h8000_0000, 0, 0, 0));
    // Live branch beats pending branch
    tbl.push_back(mk(1, 1, 0, 1, 32'h0040_0000, 0, 0, 0, 32'h8000_0004, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 32'h0050_0000, 0, 0, 0, 32'h8000_0004, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0050_0000, 0, 0, 0));
    // Reset with a pending redirect discards it; no kill while in reset
    tbl.push_back(mk(1, 1, 0, 1, 32'h0060_0000, 0, 0, 0, 32'h0050_0004, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 32'h0050_0004, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h1234_5678, 1, 32'h0050_0004, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 32'hBFC0_0000, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'hBFC0_0000, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'hBFC0_0004, 0, 0, 0));

    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      resetn = tbl[i].rstn;
      drive(tbl[i].pcf2, tbl[i].stall, tbl[i].br, tbl[i].br_t, tbl[i].exc, tbl[i].exc_pc,
            tbl[i].intr);
      #4;
      n_vec++;
      chk($sformatf("v%0d f_pc", i), bus.f_pc, tbl[i].e_pc);
      chk($sformatf("v%0d f_int", i), {31'b0, bus.f_int}, {31'b0, tbl[i].e_int});
      chk($sformatf("v%0d kill_d", i), {31'b0, bus.kill_d}, {31'b0, tbl[i].e_kill});
      chk($sformatf("v%0d pend_valid", i), {31'b0, bus.pend_valid}, {31'b0, tbl[i].e_pend});
    end

    // Exception pulse mid-transaction: PC frozen until the bus completes.
    @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0); #4; n_vec++;
    chk("busy0 f_pc", bus.f_pc, 32'hBFC0_0008);
    chk("busy0 pend_valid", {31'b0, bus.pend_valid}, 32'd0);
    @(negedge clk); drive(1, 0, 0, 0, 1, 32'hBFC0_0180, 0); #4; n_vec++;
    chk("busy1 kill_d", {31'b0, bus.kill_d}, 32'd0);
    for (int k = 2; k < 4; k++) begin
      @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0); #4; n_vec++;
      chk($sformatf("busy%0d f_pc", k), bus.f_pc, 32'hBFC0_0008);
      chk($sformatf("busy%0d pend_valid", k), {31'b0, bus.pend_valid}, 32'd1);
      chk($sformatf("busy%0d kill_d", k), {31'b0, bus.kill_d}, 32'd0);
    end
    @(negedge clk); drive(0, 1, 0, 0, 0, 0, 0); #4; n_vec++;
    chk("busy4 kill_d", {31'b0, bus.kill_d}, 32'd1);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0); #4; n_vec++;
    chk("busy5 f_pc", bus.f_pc, 32'hBFC0_0180);
    chk("busy5 pend_valid", {31'b0, bus.pend_valid}, 32'd0);
    chk("busy5 kill_d", {31'b0, bus.kill_d}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_select.md
Name: pc_select

Overview:
- Next-PC generation stage directly upstream of fetch. Owns the fetch PC register and drives the fetch stage's PC and interrupt inputs.
- Chooses among sequential PC+4, branch target from decode, and exception/ERET vector from CP0.
- Redirects that arrive while an instruction-bus transaction is in flight are held pending, so the PC never changes mid-transaction.
- Flags wrong-path instructions leaving fetch so decode inserts bubbles.

Parameters:
RESET_PC, 32'hBFC0_0000, PC loaded on reset.

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
pc_fetch  in  32  sequential successor from fetch (f_pc+4)
pcf2  in  1  fetch busy; bus data_ok not yet received (0 on misaligned PC)
stall_f  in  1  downstream hazard stall of the fetch stage
br_valid  in  1  decode resolved taken branch/jump (one-cycle pulse)
br_target  in  32  branch/jump target
exc_valid  in  1  CP0 redirect request (exception or ERET), one-cycle pulse
exc_pc  in  32  exception vector or EPC
int_req  in  1  CP0 pending-interrupt indication
f_pc  out  32  current fetch PC
f_int  out  1  interrupt tag for instruction at f_pc
kill_d  out  1  instruction leaving fetch this cycle is wrong-path; decode bubbles it
pend_valid  out  1  a redirect is held pending (visible for debug and verification)

Behaviour:
- Reset values (resetn=0 at posedge): f_pc=RESET_PC, f_int=0, pend_valid=0, pend_exc=0, pend_pc=0. kill_d=0 while in reset.
- Internal state: pend_valid, pend_exc (pending redirect is from CP0), pend_pc[31:0].
- exc_any = exc_valid | pend_exc.
- advance = ~pcf2 & (~stall_f | exc_any). An exception redirect overrides the hazard stall; it never overrides pcf2, because the bus transaction must complete first.
- next_pc priority, highest first:
  - exc_valid → exc_pc
  - pend_exc → pend_pc
  - br_valid → br_target
  - pend_valid → pend_pc
  - otherwise → pc_fetch
- On advance:
  - f_pc <= next_pc.
  - pend_valid, pend_exc <= 0.
  - f_int <= int_req & ~exc_any.
- On no advance:
  - f_pc and f_int hold.
  - If exc_valid: pend_pc <= exc_pc, pend_valid <= 1, pend_exc <= 1. This overwrites any pending branch.
  - Else if br_valid & ~pend_exc: pend_pc <= br_target, pend_valid <= 1.
  - Else pending state holds.
- kill_d = advance & exc_any (combinational). The instruction in fetch is younger than the faulting one.
- Branches never kill: the instruction in fetch when br_valid pulses is the delay slot and must complete. The target is fetched next.
- A branch arriving with a pending exception is dropped; it is wrong-path.
- A second exc_valid while pend_exc=1 replaces pend_pc (the newest CP0 redirect wins).
- Misaligned f_pc: fetch reports pcf2=0, so advance occurs the same cycle and the ADEL instruction flows downstream. No special handling here.
- Latency: a redirect seen in cycle N with advance=1 gives f_pc=target at N+1. With advance=0 it takes effect the cycle after advance first rises.
- Reset mid-transaction: the pending redirect is discarded and the PC restarts at RESET_PC. The bus-side valid restart is fetch's responsibility.
- No arithmetic here; PC+4 comes from fetch. All PCs are 32-bit, with no wrap handling beyond natural 32-bit overflow of pc_fetch.

Decomposition:
- Shared pipeline package holds:
  - RESET_PC constant
  - redirect struct {valid, is_exc, pc}
  - existing F_type: f_pc/f_int are packed into it at the top level
- One natural sub-module: redirect_hold, the pending-redirect register with priority capture logic (~60 lines).
- Top level: next-PC mux plus PC/f_int register.

Test Plan:
1. Reset, then pcf2=0, stall_f=0 for 3 cycles → f_pc = BFC0_0000, BFC0_0004, BFC0_0008; kill_d=0.
2. f_pc=BFC0_0010, pcf2=1 for 3 cycles, br_valid pulse target=BFC0_0100 in cycle 1 → pend_valid=1 for cycles 2-3; pcf2 drops in cycle 4 → f_pc=BFC0_0100 in cycle 5, pend_valid=0, kill_d=0.
3. br_valid=1, target=8000_0200, with pcf2=0, stall_f=0 → f_pc=8000_0200 next cycle; no pending state.
4. stall_f=1, pcf2=0, exc_valid pulse exc_pc=BFC0_0380 → advance despite stall; kill_d=1 that cycle; f_pc=BFC0_0380 next cycle; f_int=0.
5. pcf2=1: br_valid (target=1000) then exc_valid (exc_pc=BFC0_0380) one cycle later, then pcf2=0 → f_pc=BFC0_0380, kill_d=1 in the advance cycle, branch discarded.
6. pend_valid=1 with resetn=0 for one cycle → f_pc=BFC0_0000, pend_valid=0, f_int=0 after reset.
